// File: rtl/bound_flasher_monitor_pkg.sv
// Shared definitions for the bound flasher monitor: sweep phase encodings,
// error codes and default sweep geometry. The bench imports this package too,
// so phase and error encodings have a single source.
package bound_flasher_monitor_pkg;

    // Sweep phase as reported on the phase output
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_UP1    = 3'd1,
        PH_DN1    = 3'd2,
        PH_UP2    = 3'd3,
        PH_DN2    = 3'd4,
        PH_UP3    = 3'd5,
        PH_DN3    = 3'd6,
        PH_RESYNC = 3'd7
    } phase_e;

    // Error codes; ERR_NONE only ever appears as the reset value
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_THERMO = 2'd1;
    localparam logic [1:0] ERR_STEP   = 2'd2;
    localparam logic [1:0] ERR_FLICK  = 2'd3;

    // Default sweep geometry
    localparam int BFM_WIDTH  = 16;
    localparam int BFM_PEAK1  = 16;
    localparam int BFM_VALLEY = 5;
    localparam int BFM_PEAK2  = 11;
    localparam int BFM_PEAK3  = 6;

    // Saturation value of the kick counter
    localparam logic [7:0] KICK_MAX = 8'hFF;

endpackage

// File: rtl/bound_flasher_monitor_thermo_decode.sv
// thermo_decode: combinational decode of the LED bus. Produces the number of
// lit LEDs and a flag telling whether the bus is a clean thermometer code
// (the lit LEDs are exactly the lowest cnt positions).
module thermo_decode
    import bound_flasher_monitor_pkg::*;
#(
    parameter int WIDTH = BFM_WIDTH,
    parameter int CNT_W = $clog2(BFM_WIDTH + 1)
) (
    input  logic [WIDTH-1:0] led_in,
    output logic [CNT_W-1:0] cnt,
    output logic             is_thermo
);

    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] mask_s;

    // Popcount, then rebuild the ideal thermometer pattern for that count
    always_comb begin
        cnt_s  = {CNT_W{1'b0}};
        mask_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s = cnt_s + CNT_W'(led_in[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            mask_s[i] = (CNT_W'(i) < cnt_s);
        end
    end

    assign cnt       = cnt_s;
    assign is_thermo = (mask_s == led_in);

endmodule

// File: rtl/bound_flasher_monitor.sv
// bound_flasher_monitor: passive observer of the bound flasher LED bus.
// Stage 1 registers led_in and flick_in; stage 2 decodes the registered bus,
// tracks the sweep phase and drives registered status outputs, so a sample
// taken at edge n is reflected on the outputs after edge n+1.
// Optional build macro: BFM_STRICT_FLICK_EN -- a kick-shaped reversal with the
// flick input low is reported as err_code 3 instead of being accepted.
module bound_flasher_monitor
    import bound_flasher_monitor_pkg::*;
#(
    parameter int WIDTH  = BFM_WIDTH,
    parameter int PEAK1  = BFM_PEAK1,
    parameter int VALLEY = BFM_VALLEY,
    parameter int PEAK2  = BFM_PEAK2,
    parameter int PEAK3  = BFM_PEAK3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             led_in,
    input  logic                         flick_in,
    output logic [2:0]                   phase,
    output logic [$clog2(WIDTH+1)-1:0]   lit_count,
    output logic                         kick,
    output logic                         cycle_done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [7:0]                   kick_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PEAK1  = CNT_W'(PEAK1);
    localparam logic [CNT_W-1:0] CNT_VALLEY = CNT_W'(VALLEY);
    localparam logic [CNT_W-1:0] CNT_PEAK2  = CNT_W'(PEAK2);
    localparam logic [CNT_W-1:0] CNT_PEAK3  = CNT_W'(PEAK3);

    // Input sampling stage
    logic [WIDTH-1:0] led_q;
    logic             flick_q;

    // Decode of the sampled bus
    logic [CNT_W-1:0] cnt_s;
    logic             is_thermo_s;
    logic             step_up_s;
    logic             step_dn_s;

    // Phase tracker and output registers
    phase_e           phase_q,      phase_d;
    logic [CNT_W-1:0] prev_count_q;
    logic [CNT_W-1:0] lit_count_q;
    logic             kick_q,       kick_d;
    logic             cycle_done_q, cycle_done_d;
    logic             err_q,        err_d;
    logic [1:0]       err_code_q,   err_code_d;
    logic [7:0]       kick_count_q, kick_count_d;

    // Per-cycle classification produced by the phase logic
    logic             step_err_s;
    logic             flick_err_s;
    logic             kick_ok_s;

    // Sample the LED bus and the flick input once per clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= {WIDTH{1'b0}};
            flick_q <= 1'b0;
        end else begin
            led_q   <= led_in;
            flick_q <= flick_in;
        end
    end

    thermo_decode #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_thermo_decode (
        .led_in    (led_q),
        .cnt       (cnt_s),
        .is_thermo (is_thermo_s)
    );

    assign step_up_s = (cnt_s == prev_count_q + CNT_ONE);
    assign step_dn_s = (cnt_s + CNT_ONE == prev_count_q);

    // Classify the step against the current phase and pick the next phase
    always_comb begin
        phase_d     = phase_q;
        step_err_s  = 1'b0;
        flick_err_s = 1'b0;
        kick_ok_s   = 1'b0;
        if (phase_q == PH_RESYNC) begin
            // Errors are not re-flagged while waiting for a dark bus
            if (is_thermo_s && (cnt_s == CNT_ZERO)) begin
                phase_d = PH_IDLE;
            end else begin
                phase_d = PH_RESYNC;
            end
        end else if (!is_thermo_s) begin
            phase_d = PH_RESYNC;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (cnt_s == CNT_ZERO) begin
                        phase_d = PH_IDLE;
                    end else if (step_up_s) begin
                        phase_d = PH_UP1;
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_UP1: begin
                    if (step_up_s && (cnt_s <= CNT_PEAK1)) begin
                        phase_d = PH_UP1;
                    end else if (step_dn_s && (prev_count_q == CNT_PEAK1)) begin
                        phase_d = PH_DN1;
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_DN1: begin
                    if (step_dn_s) begin
                        phase_d = PH_DN1;
                    end else if (step_up_s && (prev_count_q <= CNT_VALLEY) && flick_q) begin
                        kick_ok_s = 1'b1;
                        phase_d   = PH_UP1;
                    end else if (step_up_s && (prev_count_q == CNT_VALLEY)) begin
                        phase_d = PH_UP2;
                    end else if (step_up_s && (prev_count_q < CNT_VALLEY)) begin
                        // Kick-shaped reversal below the valley with flick low
`ifdef BFM_STRICT_FLICK_EN
                        flick_err_s = 1'b1;
`else
                        kick_ok_s = 1'b1;
                        phase_d   = PH_UP1;
`endif
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_UP2: begin
                    if (step_up_s && (cnt_s <= CNT_PEAK2)) begin
                        phase_d = PH_UP2;
                    end else if (step_dn_s && (prev_count_q == CNT_PEAK2)) begin
                        phase_d = PH_DN2;
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_DN2: begin
                    if (step_dn_s) begin
                        phase_d = PH_DN2;
                    end else if (step_up_s && flick_q &&
                                 ((prev_count_q == CNT_ZERO) || (prev_count_q == CNT_VALLEY))) begin
                        kick_ok_s = 1'b1;
                        phase_d   = PH_UP2;
                    end else if (step_up_s && (prev_count_q == CNT_ZERO)) begin
                        phase_d = PH_UP3;
                    end else if (step_up_s && (prev_count_q == CNT_VALLEY)) begin
                        // Kick-shaped reversal at the valley with flick low
`ifdef BFM_STRICT_FLICK_EN
                        flick_err_s = 1'b1;
`else
                        kick_ok_s = 1'b1;
                        phase_d   = PH_UP2;
`endif
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_UP3: begin
                    if (step_up_s && (cnt_s <= CNT_PEAK3)) begin
                        phase_d = PH_UP3;
                    end else if (step_dn_s && (prev_count_q == CNT_PEAK3)) begin
                        phase_d = PH_DN3;
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                PH_DN3: begin
                    if (step_dn_s && (cnt_s == CNT_ZERO)) begin
                        phase_d = PH_IDLE;
                    end else if (step_dn_s) begin
                        phase_d = PH_DN3;
                    end else begin
                        step_err_s = 1'b1;
                    end
                end
                default: begin
                    step_err_s = 1'b1;
                end
            endcase
            if (step_err_s || flick_err_s) begin
                phase_d = PH_RESYNC;
            end else begin
                phase_d = phase_d;
            end
        end
    end

    // Build the pulse outputs with err > kick > cycle_done priority
    always_comb begin
        kick_d       = 1'b0;
        cycle_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        kick_count_d = kick_count_q;
        if (phase_q == PH_RESYNC) begin
            err_d = 1'b0;
        end else if (!is_thermo_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_THERMO;
        end else if (step_err_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_STEP;
        end else if (flick_err_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_FLICK;
        end else if (kick_ok_s) begin
            kick_d = 1'b1;
            if (kick_count_q != KICK_MAX) begin
                kick_count_d = kick_count_q + 8'd1;
            end else begin
                kick_count_d = kick_count_q;
            end
        end else if ((phase_q == PH_DN3) && (phase_d == PH_IDLE)) begin
            cycle_done_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
    end

    // Phase, history and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= PH_IDLE;
            prev_count_q <= CNT_ZERO;
            lit_count_q  <= CNT_ZERO;
            kick_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            kick_count_q <= 8'd0;
        end else begin
            phase_q      <= phase_d;
            prev_count_q <= cnt_s;
            lit_count_q  <= cnt_s;
            kick_q       <= kick_d;
            cycle_done_q <= cycle_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            kick_count_q <= kick_count_d;
        end
    end

    assign phase      = phase_q;
    assign lit_count  = lit_count_q;
    assign kick       = kick_q;
    assign cycle_done = cycle_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign kick_count = kick_count_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed bench for bound_flasher_monitor. Each step drives one LED vector;
// outputs read just after the following rising edge reflect the vector driven
// on the previous step (two-stage latency).
module tb_bound_flasher_monitor;
    import bound_flasher_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] led_in = 16'd0;
    logic        flick_in = 1'b0;
    logic [2:0]  phase;
    logic [4:0]  lit_count;
    logic        kick;
    logic        cycle_done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  kick_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Running observations across a sequence of steps
    int          err_seen;
    int          cd_seen;
    int          lit_bad;
    logic [23:0] phase_seq;
    logic [2:0]  last_phase;
    logic [15:0] prev_led;

    bound_flasher_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .flick_in   (flick_in),
        .phase      (phase),
        .lit_count  (lit_count),
        .kick       (kick),
        .cycle_done (cycle_done),
        .err        (err),
        .err_code   (err_code),
        .kick_count (kick_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] therm(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic clear_stats();
        err_seen   = 0;
        cd_seen    = 0;
        lit_bad    = 0;
        phase_seq  = 24'd0;
        last_phase = 3'd0;
        prev_led   = 16'd0;
    endtask

    task automatic step(input logic [15:0] v, input logic f);
        @(negedge clk);
        led_in   = v;
        flick_in = f;
        @(posedge clk);
        #1;
        if (lit_count !== 5'($countones(prev_led))) lit_bad++;
        err_seen += int'(err);
        cd_seen  += int'(cycle_done);
        if (phase != last_phase) begin
            phase_seq  = {phase_seq[20:0], phase};
            last_phase = phase;
        end
        prev_led = v;
    endtask

    task automatic ramp(input int a, input int b, input logic f);
        if (a <= b) begin
            for (int i = a; i <= b; i++) step(therm(i), f);
        end else begin
            for (int i = a; i >= b; i--) step(therm(i), f);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        led_in   = 16'd0;
        flick_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_stats();
    endtask

    initial begin
        clear_stats();
        // Reset state
        #12;
        check_val("rst_phase", 32'(phase), 32'd0);
        check_val("rst_lit", 32'(lit_count), 32'd0);
        check_val("rst_kick", 32'(kick), 32'd0);
        check_val("rst_cdone", 32'(cycle_done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_code", 32'(err_code), 32'd0);
        check_val("rst_kcnt", 32'(kick_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Legal full sweep without flick
        step(16'd0, 1'b0);
        step(16'd0, 1'b0);
        ramp(1, 16, 1'b0);
        ramp(15, 5, 1'b0);
        ramp(6, 11, 1'b0);
        ramp(10, 0, 1'b0);
        ramp(1, 6, 1'b0);
        ramp(5, 0, 1'b0);
        step(16'd0, 1'b0);
        step(16'd0, 1'b0);
        check_val("sweep_cdone", 32'(cd_seen), 32'd1);
        check_val("sweep_err", 32'(err_seen), 32'd0);
        check_val("sweep_phases", 32'(phase_seq), 32'o01234560);
        check_val("sweep_lit", 32'(lit_bad), 32'd0);
        check_val("sweep_kcnt", 32'(kick_count), 32'd0);

        // Flick kick in DN1 at count 3
        do_reset();
        step(16'd0, 1'b0);
        ramp(1, 16, 1'b0);
        ramp(15, 4, 1'b0);
        step(therm(3), 1'b1);
        step(therm(4), 1'b1);
        step(therm(5), 1'b0);
        check_val("dn1_kick", 32'(kick), 32'd1);
        check_val("dn1_kick_phase", 32'(phase), 32'(PH_UP1));
        check_val("dn1_kick_kcnt", 32'(kick_count), 32'd1);
        step(therm(6), 1'b0);
        check_val("dn1_kick_pulse", 32'(kick), 32'd0);
        check_val("dn1_kick_err", 32'(err_seen), 32'd0);

        // Flick kick in DN2 at count 0 returns to UP2
        do_reset();
        step(16'd0, 1'b0);
        ramp(1, 16, 1'b0);
        ramp(15, 5, 1'b0);
        ramp(6, 11, 1'b0);
        ramp(10, 1, 1'b0);
        step(16'd0, 1'b1);
        step(16'h0001, 1'b1);
        step(therm(2), 1'b0);
        check_val("dn2_kick", 32'(kick), 32'd1);
        check_val("dn2_kick_phase", 32'(phase), 32'(PH_UP2));
        check_val("dn2_kick_kcnt", 32'(kick_count), 32'd1);
        check_val("dn2_kick_err", 32'(err_seen), 32'd0);

        // Non-thermometer pattern in UP1, then recovery
        do_reset();
        step(16'd0, 1'b0);
        step(16'h0001, 1'b0);
        step(16'h0003, 1'b0);
        step(16'h0005, 1'b0);
        step(16'd0, 1'b0);
        check_val("thermo_err", 32'(err), 32'd1);
        check_val("thermo_code", 32'(err_code), 32'(ERR_THERMO));
        check_val("thermo_phase", 32'(phase), 32'(PH_RESYNC));
        step(16'd0, 1'b0);
        check_val("resync_idle", 32'(phase), 32'(PH_IDLE));
        check_val("resync_noerr", 32'(err), 32'd0);
        check_val("resync_code_held", 32'(err_code), 32'(ERR_THERMO));

        // Illegal +2 step in UP1
        do_reset();
        step(16'd0, 1'b0);
        ramp(1, 8, 1'b0);
        step(16'h03FF, 1'b0);
        step(16'h03FF, 1'b0);
        check_val("jump_err", 32'(err), 32'd1);
        check_val("jump_code", 32'(err_code), 32'(ERR_STEP));
        check_val("jump_nokick", 32'(kick), 32'd0);
        check_val("jump_nocdone", 32'(cycle_done), 32'd0);
        check_val("jump_phase", 32'(phase), 32'(PH_RESYNC));

        // DN1 reversal at count 3 with flick low
        do_reset();
        step(16'd0, 1'b0);
        ramp(1, 16, 1'b0);
        ramp(15, 3, 1'b0);
        step(therm(4), 1'b0);
        step(therm(5), 1'b0);
`ifdef BFM_STRICT_FLICK_EN
        check_val("strict_err", 32'(err), 32'd1);
        check_val("strict_code", 32'(err_code), 32'(ERR_FLICK));
        check_val("strict_phase", 32'(phase), 32'(PH_RESYNC));
        check_val("strict_nokick", 32'(kick), 32'd0);
`else
        check_val("loose_kick", 32'(kick), 32'd1);
        check_val("loose_phase", 32'(phase), 32'(PH_UP1));
        check_val("loose_noerr", 32'(err), 32'd0);
        check_val("loose_kcnt", 32'(kick_count), 32'd1);
`endif

        // Asynchronous reset in the middle of UP2
        do_reset();
        step(16'd0, 1'b0);
        ramp(1, 16, 1'b0);
        ramp(15, 5, 1'b0);
        ramp(6, 8, 1'b0);
        check_val("mid_up2_phase", 32'(phase), 32'(PH_UP2));
        check_val("mid_up2_lit", 32'(lit_count), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_phase", 32'(phase), 32'd0);
        check_val("async_lit", 32'(lit_count), 32'd0);
        check_val("async_err", 32'(err), 32'd0);
        check_val("async_code", 32'(err_code), 32'd0);
        check_val("async_kcnt", 32'(kick_count), 32'd0);
        @(negedge clk);
        led_in = 16'd0;
        rst    = 1'b1;
        clear_stats();
        step(16'd0, 1'b0);
        step(16'd0, 1'b0);
        check_val("post_rst_phase", 32'(phase), 32'(PH_IDLE));
        check_val("post_rst_err", 32'(err_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
